// File: rtl/mod_inv.sv
// mod_inv: computes n' = -n^-1 mod 2^64 from the low 64-bit word of a
// 4096-bit modulus. This is the Montgomery constant used by the word-serial
// multiplier. A bit-serial Hensel lift produces one bit of the inverse per
// clock, so latency is fixed at 64 cycles from the start edge to valid.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   go         in   active-low start request; high = idle/acknowledge
//   n          in   4096-bit modulus; only n[63:0] is used, sampled at start
//   modulo_inv out  signed 64-bit result (0 when n[0] is 0)
//   valid      out  high while modulo_inv holds a finished result
module mod_inv (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [4095:0]      n,
  output logic signed [63:0] modulo_inv,
  output logic               valid
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [63:0] n0_q, n0_d;
  logic [63:0] y_q, y_d;
  logic [63:0] p_q, p_d;
  logic [5:0]  i_q, i_d;
  logic [63:0] inv_q, inv_d;
  logic        valid_q, valid_d;

  // Only the low word of the modulus participates in the result.
  logic unused_n_hi;
  assign unused_n_hi = ^n[4095:64];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n0_q    <= '0;
      y_q     <= '0;
      p_q     <= '0;
      i_q     <= '0;
      inv_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n0_q    <= n0_d;
      y_q     <= y_d;
      p_q     <= p_d;
      i_q     <= i_d;
      inv_q   <= inv_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n0_d    = n0_q;
    y_d     = y_q;
    p_d     = p_q;
    i_d     = i_q;
    inv_d   = inv_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (!go) begin
          // Bit 0 is already resolved: y=1 makes n0*y = n0, odd when invertible.
          n0_d    = n[63:0];
          y_d     = 64'd1;
          p_d     = n[63:0];
          i_d     = 6'd1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // p tracks the low word of n0*y. With bits below i already cleared
        // to ...0001, a set bit i is cancelled by adding 2^i to y.
        if (p_q[i_q]) begin
          y_d = y_q | (64'd1 << i_q);
          p_d = p_q + (n0_q << i_q);
        end
        i_d = i_q + 6'd1;
        if (i_q == 6'd63) state_d = S_FIN;
      end
      S_FIN: begin
        // Even moduli have no inverse; report 0 after the same latency.
        inv_d   = n0_q[0] ? (~y_q + 64'd1) : 64'd0;
        valid_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (go) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign modulo_inv = inv_q;
  assign valid      = valid_q;

endmodule

// File: tb/tb_mod_inv.sv
// Bench for mod_inv. Expected values come from a Newton-iteration inverse
// model (x <- x*(2 - a*x)) and from fixed known-answer constants.
module tb_mod_inv;

  logic               clk;
  logic               rst_n;
  logic               go;
  logic [4095:0]      n;
  logic signed [63:0] modulo_inv;
  logic               valid;

  int n_chk  = 0;
  int n_fail = 0;

  mod_inv dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .n          (n),
    .modulo_inv (modulo_inv),
    .valid      (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_inv(input logic [63:0] a);
    logic [63:0] x;
    if (!a[0]) return 64'd0;
    x = a;  // a*a == 1 mod 8 for odd a, each step doubles the precision
    for (int k = 0; k < 6; k++) x = x * (64'd2 - a * x);
    return -x;
  endfunction

  // Start a computation and wait for valid, keeping go low. Optionally swap
  // n after swap_at cycles to show the operand is captured at start.
  task automatic run_op(input logic [4095:0] nv, input int swap_at,
                        input logic [4095:0] n_alt,
                        output logic [63:0] res, output int lat);
    @(negedge clk);
    n  = nv;
    go = 1'b0;
    @(posedge clk);  // start edge E0
    @(negedge clk);
    lat = 0;
    while (!valid && lat < 200) begin
      if (lat == swap_at) n = n_alt;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = modulo_inv;
  endtask

  task automatic release_go(input string tag);
    go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(tag, {63'd0, valid}, 64'd0);
  endtask

  task automatic full_run(input string tag, input logic [4095:0] nv, input logic [63:0] exp);
    logic [63:0] r;
    int lat;
    run_op(nv, -1, '0, r, lat);
    chk({tag, "_lat"}, 64'(lat), 64'd64);
    chk({tag, "_res"}, r, exp);
    chk({tag, "_model"}, r, ref_inv(nv[63:0]));
    release_go({tag, "_clr"});
  endtask

  initial begin
    logic [63:0]   r, rnd, held;
    logic [4095:0] big;
    int            lat;

    rst_n = 1'b0;
    go    = 1'b1;
    n     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with go high: nothing happens.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_valid", {63'd0, valid}, 64'd0);
      chk("idle_inv", modulo_inv, 64'd0);
    end

    full_run("n1", 4096'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    full_run("n3", 4096'd3, 64'h5555_5555_5555_5555);
    full_run("nff", {4032'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 64'h0000_0000_0000_0001);
    big = '1;
    big[63:0] = 64'h3;
    full_run("nhi", big, 64'h5555_5555_5555_5555);

    full_run("ev10", 4096'h10, 64'd0);
    full_run("ev10000", 4096'h10000, 64'd0);
    full_run("ev0", 4096'd0, 64'd0);

    // Random odd and even operands against the model.
    for (int t = 0; t < 8; t++) begin
      rnd = {$urandom, $urandom};
      if (t < 6) rnd[0] = 1'b1; else rnd[0] = 1'b0;
      big = {$urandom, $urandom, $urandom, $urandom};
      big[63:0] = rnd;
      run_op(big, -1, '0, r, lat);
      chk("rnd_lat", 64'(lat), 64'd64);
      chk("rnd_model", r, ref_inv(rnd));
      if (rnd[0]) chk("rnd_prod", rnd * r, 64'hFFFF_FFFF_FFFF_FFFF);
      release_go("rnd_clr");
    end

    // Reset 30 cycles into CALC aborts with no valid.
    @(negedge clk);
    n  = 4096'd3;
    go = 1'b0;
    @(posedge clk);
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {63'd0, valid}, 64'd0);
    chk("abort_inv", modulo_inv, 64'd0);
    go = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      chk("abort_quiet", {63'd0, valid}, 64'd0);
    end
    full_run("n5", 4096'd5, 64'h3333_3333_3333_3333);

    // Hold go low in DONE: result and valid stay put, no recompute.
    run_op(4096'd7, -1, '0, r, lat);
    chk("hold_lat", 64'(lat), 64'd64);
    held = r;
    n = 4096'd9;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, valid}, 64'd1);
      chk("hold_inv", modulo_inv, held);
    end
    chk("hold_model", held, ref_inv(64'd7));
    release_go("hold_clr");

    // n changes mid-CALC; result reflects the captured operand.
    run_op(4096'd3, 5, 4096'd5, r, lat);
    chk("swap_lat", 64'(lat), 64'd64);
    chk("swap_res", r, 64'h5555_5555_5555_5555);
    release_go("swap_clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_inv.md
# mod_inv

Computes the Montgomery constant n' = −n⁻¹ mod 2⁶⁴ from the least-significant 64-bit word of a 4096-bit Paillier modulus n. It feeds the word-serial Montgomery multiplier in the Paillier datapath. The block uses a bit-serial Hensel-lifting loop: one result bit per clock, fixed latency, and a level handshake on `go`/`valid`.

## Interface
- No parameters. Operand width is fixed at 4096 bits and word width at 64 bits.
- `clk` input, 1 bit. System clock; all state changes on the rising edge.
- `rst_n` input, 1 bit. Asynchronous, active-low reset.
- `go` input, 1 bit. Active-low start request. High means idle/acknowledge; low requests a computation.
- `n` input, 4096 bits. Modulus. Only `n[63:0]` is used. It must be stable on the edge that samples `go` low.
- `modulo_inv` output, signed 64 bits. Result n' = −(n[63:0])⁻¹ mod 2⁶⁴.
- `valid` output, 1 bit. High while `modulo_inv` holds a finished result.

## Operation
- Registers:
  - `n0` (64 bits): captured operand.
  - `y` (64 bits): partial inverse.
  - `p` (64 bits): running low word of n0·y.
  - `i` (6 bits): iteration counter.
  - `modulo_inv`, `valid`.
  - Small FSM.
- FSM states and transitions:
  - **IDLE:** if `go`==0 at a rising edge, load `n0`←`n[63:0]`, `y`←1, `p`←`n[63:0]`, `i`←1, and go to CALC. Otherwise stay in IDLE.
  - **CALC:** each edge performs one iteration for bit i:
    - if `p[i]`==1 then `y[i]`←1 and `p`←`p`+(`n0`<<i) (mod 2⁶⁴);
    - then `i`←i+1.
    - After i=63 is processed, go to FIN.
  - **FIN:**
    - if `n0[0]`==1, `modulo_inv`←(~y)+1 (two's complement negate, mod 2⁶⁴);
    - if `n0[0]`==0, `modulo_inv`←0, since no inverse exists for even n;
    - `valid`←1; go to DONE.
  - **DONE:** hold `modulo_inv` and `valid`=1 while `go`==0. When `go`==1 at an edge, clear `valid` and go to IDLE. `modulo_inv` keeps its last value.
- Invariant in CALC (odd `n0`): n0·y ≡ 1 mod 2^i before processing bit i. After bit 63, n0·y ≡ 1 mod 2⁶⁴.
- Even `n0` takes the same path and latency; only the FIN result differs (forced to 0).
- `go` and `n` are ignored while in CALC and FIN. A new request is accepted only from IDLE, so `go` must return high (visit DONE→IDLE) before the next start.
- All arithmetic is unsigned modulo 2⁶⁴. `modulo_inv` is declared signed only for consumer convenience; its bit pattern is the unsigned result.
- Bits `n[4095:64]` have no effect.

## Timing
- Reset (`rst_n`=0, asynchronous): state←IDLE, `valid`←0, `modulo_inv`←0, and `n0`, `y`, `p`, `i`←0. Reset asserted at any point, including mid-CALC, aborts the computation immediately with no stale `valid`.
- Latency: let edge E0 be the edge that samples `go`=0 in IDLE.
  - CALC iterations occur on E1…E63.
  - FIN executes on E64, so `valid` is first seen high after E64.
  - Total: 64 cycles from the start edge to `valid`.
- `valid` falls on the first edge in DONE that samples `go`=1. If `go` is already high when DONE is entered, `valid` is high for exactly one cycle.
- Minimum restart: from `valid` falling (E_k), a start can be sampled at E_k+1 at the earliest.
- If `go` is held low continuously, the block stays in DONE and does not recompute.

## Test plan
- Apply reset, then hold `go`=1 for 10 cycles → `valid`=0 and `modulo_inv`=0 throughout.
- Set n=1 and pulse `go` low until `valid` → `modulo_inv`=0xFFFFFFFFFFFFFFFF; `valid` rises exactly 64 edges after the start edge; returning `go` high clears `valid` on the next edge.
- Run n=3, then n=0xFFFFFFFFFFFFFFFF, then n with bits above 63 set and low word 0x3 → results 0x5555555555555555, 0x0000000000000001 and 0x5555555555555555. For a random odd n, n[63:0]·modulo_inv ≡ −1 mod 2⁶⁴.
- Run even n = 0x10, 0x10000 and 0 → `modulo_inv`=0 and `valid` after the same 64-cycle latency.
- Start n=3, assert `rst_n`=0 at cycle 30 of CALC, release, then start n=5 → no `valid` during or after the abort; the second run gives 0x3333333333333333 (since 5·0xCCCCCCCCCCCCCCCD ≡ 1).
- Hold `go` low through DONE for 20 cycles → no recompute, `valid` and result stable. Change `n` during CALC → result reflects the captured n.
